// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter and fixed-latency sequencer for the shared memory port
typedef enum logic [1:0] {
  MEM_ACCESS_BYTE = 2'd0,
  MEM_ACCESS_HALF = 2'd1,
  MEM_ACCESS_WORD = 2'd2
} mem_access_t;

typedef logic [3:0] mem_exception_mask_t;

module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY    = 1,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic [31:0]         c_addr,
  input  logic [31:0]         c_wr_data,
  input  logic                c_wr_ena,
  input  mem_access_t         c_access,
  output logic                c_gnt,
  output logic                c_done,
  output logic [31:0]         c_rd_data,
  output mem_exception_mask_t c_exception,
  input  logic                d_req,
  input  logic [31:0]         d_addr,
  input  logic [31:0]         d_wr_data,
  input  logic                d_wr_ena,
  input  mem_access_t         d_access,
  output logic                d_gnt,
  output logic                d_done,
  output logic [31:0]         d_rd_data,
  output mem_exception_mask_t d_exception,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wr_data,
  output logic                mem_wr_ena,
  output mem_access_t         mem_access,
  input  logic [31:0]         mem_rd_data,
  input  mem_exception_mask_t mem_exception,
  output logic                busy,
  output logic [31:0]         access_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  // S_ACCESS and S_RESP each take one cycle, so S_WAIT covers the remaining MEM_LATENCY-1.
  localparam logic [3:0] WAIT_LOAD = (MEM_LATENCY >= 2) ? 4'(MEM_LATENCY - 2) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        owner;
  logic        last_owner;
  logic        wr_ena_q;

  always_comb begin
    state_nxt = state;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rst) begin
          // Requester 0 takes a tie when it was not served last or priority is fixed.
          if (c_req && (!d_req || FIXED_PRIORITY || last_owner)) begin
            c_gnt     = 1'b1;
            state_nxt = S_ACCESS;
          end else if (d_req) begin
            d_gnt     = 1'b1;
            state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: state_nxt = (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:   if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= 4'd0;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      wr_ena_q     <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wr_data  <= 32'd0;
      mem_access   <= MEM_ACCESS_WORD;
      c_done       <= 1'b0;
      d_done       <= 1'b0;
      c_rd_data    <= 32'd0;
      d_rd_data    <= 32'd0;
      c_exception  <= '0;
      d_exception  <= '0;
      access_count <= 32'd0;
    end else begin
      state  <= state_nxt;
      c_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (c_gnt || d_gnt) begin
            owner       <= d_gnt;
            mem_addr    <= d_gnt ? d_addr    : c_addr;
            mem_wr_data <= d_gnt ? d_wr_data : c_wr_data;
            wr_ena_q    <= d_gnt ? d_wr_ena  : c_wr_ena;
            mem_access  <= d_gnt ? d_access  : c_access;
          end
        end
        S_ACCESS: wait_cnt <= WAIT_LOAD;
        S_WAIT:   wait_cnt <= wait_cnt - 4'd1;
        S_RESP: begin
          if (owner) begin
            d_rd_data   <= mem_rd_data;
            d_exception <= mem_exception;
            d_done      <= 1'b1;
          end else begin
            c_rd_data   <= mem_rd_data;
            c_exception <= mem_exception;
            c_done      <= 1'b1;
          end
          access_count <= access_count + 32'd1;
          last_owner   <= owner;
        end
        default: ;
      endcase
    end
  end

  assign mem_wr_ena = (state == S_ACCESS) && wr_ena_q;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (instance 0: latency 1 round-robin, instance 1: latency 3 fixed priority)
module tb_mem_port_arbiter;

  logic clk;
  int   checks;
  int   failures;

  logic                rst           [2];
  logic                c_req         [2];
  logic [31:0]         c_addr        [2];
  logic [31:0]         c_wr_data     [2];
  logic                c_wr_ena      [2];
  mem_access_t         c_access      [2];
  logic                c_gnt         [2];
  logic                c_done        [2];
  logic [31:0]         c_rd_data     [2];
  mem_exception_mask_t c_exception   [2];
  logic                d_req         [2];
  logic [31:0]         d_addr        [2];
  logic [31:0]         d_wr_data     [2];
  logic                d_wr_ena      [2];
  mem_access_t         d_access      [2];
  logic                d_gnt         [2];
  logic                d_done        [2];
  logic [31:0]         d_rd_data     [2];
  mem_exception_mask_t d_exception   [2];
  logic [31:0]         mem_addr      [2];
  logic [31:0]         mem_wr_data   [2];
  logic                mem_wr_ena    [2];
  mem_access_t         mem_access    [2];
  logic                busy          [2];
  logic [31:0]         access_count  [2];
  logic [31:0]         junk          [2];
  mem_exception_mask_t exc_force     [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam bit FP  = (g == 1);

    logic [31:0] mem_rd_data_l;
    logic [31:0] dut_word, mdl_word;
    bit          wvalid [64];
    logic [31:0] wmem   [64];

    // Model: a transaction occupies LAT+1 busy cycles after the grant; the first is the
    // strobe cycle, the last is the sampling cycle, and done shows one cycle later.
    int                  m_cnt;
    logic                m_own, m_last, m_wr;
    logic [31:0]         m_addr, m_wdata, m_count;
    mem_access_t         m_acc;
    logic                m_done_c, m_done_d;
    logic [31:0]         m_rd_c, m_rd_d;
    mem_exception_mask_t m_ex_c, m_ex_d;
    logic                e_gc, e_gd;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .FIXED_PRIORITY(FP)) dut (
      .clk(clk), .rst(rst[g]),
      .c_req(c_req[g]), .c_addr(c_addr[g]), .c_wr_data(c_wr_data[g]), .c_wr_ena(c_wr_ena[g]),
      .c_access(c_access[g]), .c_gnt(c_gnt[g]), .c_done(c_done[g]), .c_rd_data(c_rd_data[g]),
      .c_exception(c_exception[g]),
      .d_req(d_req[g]), .d_addr(d_addr[g]), .d_wr_data(d_wr_data[g]), .d_wr_ena(d_wr_ena[g]),
      .d_access(d_access[g]), .d_gnt(d_gnt[g]), .d_done(d_done[g]), .d_rd_data(d_rd_data[g]),
      .d_exception(d_exception[g]),
      .mem_addr(mem_addr[g]), .mem_wr_data(mem_wr_data[g]), .mem_wr_ena(mem_wr_ena[g]),
      .mem_access(mem_access[g]), .mem_rd_data(mem_rd_data_l), .mem_exception(exc_force[g]),
      .busy(busy[g]), .access_count(access_count[g])
    );

    function automatic logic [31:0] init_word(input logic [5:0] idx);
      if (idx == 6'd1) return (g == 0) ? 32'h00A0_0513 : 32'h1234_5678;
      return {8'h5A, 18'd0, idx};
    endfunction

    always_comb begin
      dut_word = wvalid[mem_addr[g][7:2]] ? wmem[mem_addr[g][7:2]] : init_word(mem_addr[g][7:2]);
      mdl_word = wvalid[m_addr[7:2]] ? wmem[m_addr[7:2]] : init_word(m_addr[7:2]);
    end
    assign mem_rd_data_l = dut_word ^ junk[g];

    always_comb begin
      e_gc = 1'b0;
      e_gd = 1'b0;
      if (!rst[g] && m_cnt == 0) begin
        if (c_req[g] && !d_req[g])      e_gc = 1'b1;
        else if (d_req[g] && !c_req[g]) e_gd = 1'b1;
        else if (c_req[g] && d_req[g]) begin
          if (FP || m_last == 1'b1) e_gc = 1'b1;
          else                      e_gd = 1'b1;
        end
      end
    end

    always @(posedge clk) begin
      if (rst[g]) begin
        m_cnt <= 0;  m_own <= 1'b0; m_last <= 1'b1; m_wr <= 1'b0;
        m_addr <= 32'd0; m_wdata <= 32'd0; m_acc <= MEM_ACCESS_WORD; m_count <= 32'd0;
        m_done_c <= 1'b0; m_done_d <= 1'b0; m_rd_c <= 32'd0; m_rd_d <= 32'd0;
        m_ex_c <= '0; m_ex_d <= '0;
      end else begin
        m_done_c <= 1'b0;
        m_done_d <= 1'b0;
        if (m_cnt == 0) begin
          if (e_gc || e_gd) begin
            m_cnt   <= LAT + 1;
            m_own   <= e_gd;
            m_addr  <= e_gd ? d_addr[g]    : c_addr[g];
            m_wdata <= e_gd ? d_wr_data[g] : c_wr_data[g];
            m_wr    <= e_gd ? d_wr_ena[g]  : c_wr_ena[g];
            m_acc   <= e_gd ? d_access[g]  : c_access[g];
          end
        end else begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == LAT + 1 && m_wr) begin
            wmem[m_addr[7:2]]   <= m_wdata;
            wvalid[m_addr[7:2]] <= 1'b1;
          end
          if (m_cnt == 1) begin
            if (m_own) begin
              m_done_d <= 1'b1; m_rd_d <= mdl_word ^ junk[g]; m_ex_d <= exc_force[g];
            end else begin
              m_done_c <= 1'b1; m_rd_c <= mdl_word ^ junk[g]; m_ex_c <= exc_force[g];
            end
            m_count <= m_count + 32'd1;
            m_last  <= m_own;
          end
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("g%0d_c_gnt", g), {31'd0, c_gnt[g]}, {31'd0, e_gc});
      chk($sformatf("g%0d_d_gnt", g), {31'd0, d_gnt[g]}, {31'd0, e_gd});
      chk($sformatf("g%0d_c_done", g), {31'd0, c_done[g]}, {31'd0, m_done_c});
      chk($sformatf("g%0d_d_done", g), {31'd0, d_done[g]}, {31'd0, m_done_d});
      chk($sformatf("g%0d_c_rd_data", g), c_rd_data[g], m_rd_c);
      chk($sformatf("g%0d_d_rd_data", g), d_rd_data[g], m_rd_d);
      chk($sformatf("g%0d_c_exception", g), {28'd0, c_exception[g]}, {28'd0, m_ex_c});
      chk($sformatf("g%0d_d_exception", g), {28'd0, d_exception[g]}, {28'd0, m_ex_d});
      chk($sformatf("g%0d_mem_addr", g), mem_addr[g], m_addr);
      chk($sformatf("g%0d_mem_wr_data", g), mem_wr_data[g], m_wdata);
      chk($sformatf("g%0d_mem_access", g), {30'd0, mem_access[g]}, {30'd0, m_acc});
      chk($sformatf("g%0d_mem_wr_ena", g), {31'd0, mem_wr_ena[g]}, {31'd0, (m_cnt == LAT + 1) && m_wr});
      chk($sformatf("g%0d_busy", g), {31'd0, busy[g]}, {31'd0, m_cnt != 0});
      chk($sformatf("g%0d_access_count", g), access_count[g], m_count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int g, input bit use_d, output int waited);
    waited = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (use_d ? d_gnt[g] : c_gnt[g]) begin
        waited = k;
        break;
      end
      step();
    end
  endtask

  int      w, cg, dg, wr_cnt, seen;
  string   order;
  int      gnt_at [4];
  int      n_gnt;

  initial begin
    checks = 0;
    failures = 0;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; c_req[g] = 1'b0; d_req[g] = 1'b0;
      c_addr[g] = 32'd0; c_wr_data[g] = 32'd0; c_wr_ena[g] = 1'b0; c_access[g] = MEM_ACCESS_WORD;
      d_addr[g] = 32'd0; d_wr_data[g] = 32'd0; d_wr_ena[g] = 1'b0; d_access[g] = MEM_ACCESS_WORD;
      junk[g] = 32'd0; exc_force[g] = '0;
    end
    step();
    step();
    @(negedge clk);
    chk("reset_busy", {31'd0, busy[0]}, 32'd0);
    chk("reset_count", access_count[1], 32'd0);
    chk("reset_mem_access", {30'd0, mem_access[0]}, {30'd0, MEM_ACCESS_WORD});
    chk("reset_c_rd_data", c_rd_data[0], 32'd0);
    step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();

    // Core read at latency 1
    c_addr[0] = 32'h1000_0004; c_req[0] = 1'b1;
    @(negedge clk);
    chk("read_c_gnt_same_cycle", {31'd0, c_gnt[0]}, 32'd1);
    step(); c_req[0] = 1'b0;
    @(negedge clk);
    chk("read_mem_addr_t1", mem_addr[0], 32'h1000_0004);
    step();
    @(negedge clk);
    chk("read_mem_addr_t2", mem_addr[0], 32'h1000_0004);
    step();
    @(negedge clk);
    chk("read_c_done_t3", {31'd0, c_done[0]}, 32'd1);
    chk("read_c_rd_data", c_rd_data[0], 32'h00A0_0513);
    chk("read_count", access_count[0], 32'd1);
    step();

    // Round-robin tie straight out of reset
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    c_addr[0] = 32'h1000_0008; d_addr[0] = 32'h1000_000C;
    c_req[0] = 1'b1; d_req[0] = 1'b1;
    order = ""; n_gnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (c_gnt[0]) order = {order, "c"};
      if (d_gnt[0]) order = {order, "d"};
      if ((c_gnt[0] || d_gnt[0]) && n_gnt < 4) begin
        gnt_at[n_gnt] = k;
        n_gnt++;
      end
      step();
    end
    c_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("rr_order", {31'd0, order == "cdcd"}, 32'd1);
    chk("rr_spacing", gnt_at[3] - gnt_at[0], 32'd9);
    repeat (4) step();

    // DMA write, then a core read of the same word with a forced exception in S_RESP
    d_addr[0] = 32'h1000_0010; d_wr_data[0] = 32'hDEAD_BEEF; d_wr_ena[0] = 1'b1; d_req[0] = 1'b1;
    wait_gnt(0, 1'b1, w);
    chk("wr_gnt_seen", {31'd0, w >= 0}, 32'd1);
    step(); d_req[0] = 1'b0;
    wr_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_wr_ena[0]) wr_cnt++;
      step();
    end
    chk("wr_strobe_cycles", wr_cnt, 32'd1);
    d_wr_ena[0] = 1'b0;
    c_addr[0] = 32'h1000_0010; c_req[0] = 1'b1;
    @(negedge clk);
    chk("exc_c_gnt", {31'd0, c_gnt[0]}, 32'd1);
    step(); c_req[0] = 1'b0;
    step(); exc_force[0] = 4'b0100;
    step(); exc_force[0] = 4'b0000;
    @(negedge clk);
    chk("exc_c_done", {31'd0, c_done[0]}, 32'd1);
    chk("exc_c_exception", {28'd0, c_exception[0]}, 32'h4);
    chk("exc_c_rd_data", c_rd_data[0], 32'hDEAD_BEEF);
    step();

    // Fixed priority on instance 1
    c_addr[1] = 32'h1000_0020; d_addr[1] = 32'h1000_0024;
    c_req[1] = 1'b1; d_req[1] = 1'b1;
    cg = 0; dg = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (c_gnt[1]) cg++;
      if (d_gnt[1]) dg++;
      step();
    end
    chk("fp_d_gnt_count", dg, 32'd0);
    chk("fp_c_gnt_count", cg, 32'd4);
    c_req[1] = 1'b0;
    wait_gnt(1, 1'b1, w);
    chk("fp_d_gnt_next_idle", w, 32'd0);
    step(); d_req[1] = 1'b0;
    repeat (8) step();

    // Latency 3 with mem_rd_data churning before the sampling cycle
    c_addr[1] = 32'h1000_0004; c_req[1] = 1'b1;
    @(negedge clk);
    chk("lat3_c_gnt", {31'd0, c_gnt[1]}, 32'd1);
    step(); c_req[1] = 1'b0; junk[1] = 32'hFFFF_0000;
    step(); junk[1] = 32'h0F0F_0F0F;
    @(negedge clk);
    chk("lat3_busy_t2", {31'd0, busy[1]}, 32'd1);
    step(); junk[1] = 32'hAAAA_AAAA;
    step(); junk[1] = 32'd0;
    @(negedge clk);
    chk("lat3_no_done_t4", {31'd0, c_done[1]}, 32'd0);
    step();
    @(negedge clk);
    chk("lat3_c_done_t5", {31'd0, c_done[1]}, 32'd1);
    chk("lat3_c_rd_data", c_rd_data[1], 32'h1234_5678);
    step();

    // Reset while in S_WAIT, then a clean transaction
    c_addr[1] = 32'h1000_0008; c_req[1] = 1'b1;
    wait_gnt(1, 1'b0, w);
    chk("rstw_gnt_seen", {31'd0, w >= 0}, 32'd1);
    step(); c_req[1] = 1'b0;
    step(); rst[1] = 1'b1;
    step(); rst[1] = 1'b0;
    @(negedge clk);
    chk("rstw_busy", {31'd0, busy[1]}, 32'd0);
    chk("rstw_count", access_count[1], 32'd0);
    chk("rstw_no_done", {31'd0, c_done[1]}, 32'd0);
    repeat (4) step();
    c_req[1] = 1'b1;
    wait_gnt(1, 1'b0, w);
    chk("rstw_regnt_seen", {31'd0, w >= 0}, 32'd1);
    step(); c_req[1] = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (c_done[1]) begin
        seen = 1;
        break;
      end
      step();
    end
    chk("rstw_recover_done", seen, 32'd1);
    chk("rstw_recover_count", access_count[1], 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
